// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel strobe in, raster timing and text-cell coordinates out.
interface vga_timing_if #(
    parameter int CNT_W       = 12,
    parameter int ADDR_W      = 12,
    parameter int CELL_W_LOG2 = 3,
    parameter int CELL_H_LOG2 = 4
);
    logic                   en;
    logic                   hsync;
    logic                   vsync;
    logic                   visible;
    logic [CNT_W-1:0]       column;
    logic [CNT_W-1:0]       line;
    logic [CELL_W_LOG2-1:0] pix_x;
    logic [CELL_H_LOG2-1:0] pix_y;
    logic [CNT_W-1:0]       sym_x;
    logic [CNT_W-1:0]       sym_y;
    logic [ADDR_W-1:0]      cell_addr;
    logic                   line_start;
    logic                   frame_start;

    modport master (
        input  en,
        output hsync, vsync, visible, column, line, pix_x, pix_y,
               sym_x, sym_y, cell_addr, line_start, frame_start
    );

    modport slave (
        output en,
        input  hsync, vsync, visible, column, line, pix_x, pix_y,
               sym_x, sym_y, cell_addr, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with multiplier-free text-cell addressing.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/visible by one pixel for the registered glyph ROM.
module vga_timing_gen #(
    parameter int H_VA        = 640,
    parameter int H_FP        = 16,
    parameter int H_SP        = 96,
    parameter int H_BP        = 48,
    parameter int V_VA        = 480,
    parameter int V_FP        = 10,
    parameter int V_SP        = 2,
    parameter int V_BP        = 33,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int CELL_W_LOG2 = 3,
    parameter int CELL_H_LOG2 = 4,
    parameter int TEXT_COLS   = 80,
    parameter int CNT_W       = 12,
    parameter int ADDR_W      = 12
) (
    input logic          clk,
    input logic          reset,
    vga_timing_if.master bus
);
    localparam int H_TOTAL = H_VA + H_FP + H_SP + H_BP;
    localparam int V_TOTAL = V_VA + V_FP + V_SP + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VA);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VA);
    localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_VA + H_FP);
    localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_VA + H_FP + H_SP);
    localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_VA + V_FP);
    localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_VA + V_FP + V_SP);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(TEXT_COLS);

    if (H_FP <= 0 || H_SP <= 0 || H_BP <= 0 || V_FP <= 0 || V_SP <= 0 || V_BP <= 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be positive");
    end
    if (H_TOTAL >= 2**CNT_W || V_TOTAL >= 2**CNT_W) begin : g_bad_cnt_w
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W");
    end

    logic [CNT_W-1:0]  column, line, col_n, line_n, sym_x;
    logic [ADDR_W-1:0] row_base, row_base_n;
    logic              col_wrap, frame_wrap;
    logic              hs, vs, vis, hs_n, vs_n, vis_n;

    // Sync/visible are decoded from the next counter values so they register in step with the counters.
    always_comb begin
        col_wrap   = bus.en && column == H_LAST;
        frame_wrap = col_wrap && line == V_LAST;
        col_n      = !bus.en ? column : col_wrap ? '0 : column + 1'b1;
        line_n     = !col_wrap ? line : frame_wrap ? '0 : line + 1'b1;
        row_base_n = frame_wrap ? '0 :
                     (col_wrap && line_n < V_VIS && line_n[CELL_H_LOG2-1:0] == '0) ? row_base + STRIDE :
                     row_base;
        hs_n       = (col_n >= HS_B && col_n < HS_E) ? HSYNC_POL : !HSYNC_POL;
        vs_n       = (line_n >= VS_B && line_n < VS_E) ? VSYNC_POL : !VSYNC_POL;
        vis_n      = col_n < H_VIS && line_n < V_VIS;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            column   <= '0;
            line     <= '0;
            row_base <= '0;
            hs       <= !HSYNC_POL;
            vs       <= !VSYNC_POL;
            vis      <= 1'b1;
        end else begin
            column   <= col_n;
            line     <= line_n;
            row_base <= row_base_n;
            hs       <= hs_n;
            vs       <= vs_n;
            vis      <= vis_n;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d, vs_d, vis_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d  <= !HSYNC_POL;
            vs_d  <= !VSYNC_POL;
            vis_d <= 1'b1;
        end else if (bus.en) begin
            hs_d  <= hs;
            vs_d  <= vs;
            vis_d <= vis;
        end
    end

    assign bus.hsync   = hs_d;
    assign bus.vsync   = vs_d;
    assign bus.visible = vis_d;
`else
    assign bus.hsync   = hs;
    assign bus.vsync   = vs;
    assign bus.visible = vis;
`endif

    assign sym_x           = column >> CELL_W_LOG2;
    assign bus.column      = column;
    assign bus.line        = line;
    assign bus.pix_x       = column[CELL_W_LOG2-1:0];
    assign bus.pix_y       = line[CELL_H_LOG2-1:0];
    assign bus.sym_x       = sym_x;
    assign bus.sym_y       = line >> CELL_H_LOG2;
    assign bus.cell_addr   = row_base + ADDR_W'(sym_x);
    assign bus.line_start  = bus.en && column == '0;
    assign bus.frame_start = bus.en && column == '0 && line == '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized en/reset stimulus checked every cycle against a pixel-count model
// on a reduced 64x45 raster with 8x16 cells and 6 text columns.
module tb_vga_timing_gen;
    localparam int H_VA = 44, H_FP = 4, H_SP = 6, H_BP = 10;
    localparam int V_VA = 36, V_FP = 3, V_SP = 2, V_BP = 4;
    localparam int TC = 6, CNT_W = 8, ADDR_W = 12;
    localparam int HT = H_VA + H_FP + H_SP + H_BP;
    localparam int VT = V_VA + V_FP + V_SP + V_BP;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0, n_fail = 0;
    int   k = 0, dk = 0;
    bit   started = 1'b0;

    vga_timing_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .CELL_W_LOG2(3), .CELL_H_LOG2(4)) bus ();

    vga_timing_gen #(
        .H_VA(H_VA), .H_FP(H_FP), .H_SP(H_SP), .H_BP(H_BP),
        .V_VA(V_VA), .V_FP(V_FP), .V_SP(V_SP), .V_BP(V_BP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CELL_W_LOG2(3), .CELL_H_LOG2(4),
        .TEXT_COLS(TC), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int col_of(int x);
        return x % HT;
    endfunction

    function automatic int line_of(int x);
        return (x / HT) % VT;
    endfunction

    function automatic int hs_of(int x);
        return (col_of(x) >= H_VA + H_FP && col_of(x) < H_VA + H_FP + H_SP) ? 0 : 1;
    endfunction

    function automatic int vs_of(int x);
        return (line_of(x) >= V_VA + V_FP && line_of(x) < V_VA + V_FP + V_SP) ? 0 : 1;
    endfunction

    function automatic int vis_of(int x);
        return (col_of(x) < H_VA && line_of(x) < V_VA) ? 1 : 0;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t (k=%0d)", nm, act, exp, $time, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model state is just the number of enabled pixels since reset (k) and its one-pixel-late copy (dk).
    always @(posedge clk) begin
        if (reset) begin
            k       <= 0;
            dk      <= 0;
            started <= 1'b1;
        end else if (bus.en) begin
            k  <= k + 1;
            dk <= k;
        end
    end

    always @(negedge clk) begin
        int c, l, sk;
        if (started) begin
            c = col_of(k);
            l = line_of(k);
`ifdef VGA_SYNC_DELAY_EN
            sk = dk;
`else
            sk = k;
`endif
            chk("column", int'(bus.column), c);
            chk("line", int'(bus.line), l);
            chk("pix_x", int'(bus.pix_x), c % 8);
            chk("pix_y", int'(bus.pix_y), l % 16);
            chk("sym_x", int'(bus.sym_x), c / 8);
            chk("sym_y", int'(bus.sym_y), l / 16);
            chk("line_start", int'(bus.line_start), (bus.en && c == 0) ? 1 : 0);
            chk("frame_start", int'(bus.frame_start), (bus.en && c == 0 && l == 0) ? 1 : 0);
            chk("hsync", int'(bus.hsync), hs_of(sk));
            chk("vsync", int'(bus.vsync), vs_of(sk));
            chk("visible", int'(bus.visible), vis_of(sk));
            if (vis_of(k) == 1)
                chk("cell_addr", int'(bus.cell_addr), ((l / 16) * TC + c / 8) % (2 ** ADDR_W));
            if (c == 8 && l == 16)
                chk("addr_l16_c8", int'(bus.cell_addr), 7);
            if (c == 43 && l == 35)
                chk("addr_l35_c43", int'(bus.cell_addr), 17);
            if (c == 0 && l == 0 && k >= FR)
                chk("addr_wrap", int'(bus.cell_addr), 0);
            if (col_of(sk) == 48)
                chk("hs_first_low", int'(bus.hsync), 0);
            if (col_of(sk) == 47)
                chk("hs_last_high", int'(bus.hsync), 1);
            if (col_of(sk) == 44 && line_of(sk) == 0)
                chk("vis_drop", int'(bus.visible), 0);
        end
    end

    initial begin
        int n, cnt, vlow;
        reset  = 1'b1;
        bus.en = 1'b1;
        step();
        step();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < HT; i++) begin
            @(negedge clk);
            cnt += (bus.hsync == 1'b0) ? 1 : 0;
        end
        chk("hs_low_width", cnt, 6);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 4000);
        chk("fs_seen", int'(bus.frame_start), 1);
        n = 0;
        vlow = 0;
        do begin
            @(negedge clk);
            n++;
            vlow += (bus.vsync == 1'b0) ? 1 : 0;
        end while (!bus.frame_start && n < 4000);
        chk("frame_period", n, 2880);
        chk("vs_low_width", vlow, 128);
        step();
        for (int i = 0; i < 400; i++) begin
            bus.en = i[0];
            step();
        end
        for (int i = 0; i < 6000; i++) begin
            bus.en = ($urandom_range(0, 3) != 0);
            reset  = ($urandom_range(0, 1999) == 0);
            step();
        end
        reset  = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (col_of(k) == 30 && line_of(k) == 20)
                break;
            step();
        end
        chk("mid_pos_reached", line_of(k) * HT + col_of(k), 20 * HT + 30);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_column", int'(bus.column), 0);
        chk("rst_line", int'(bus.line), 0);
        chk("rst_hsync", int'(bus.hsync), 1);
        chk("rst_vsync", int'(bus.vsync), 1);
        chk("rst_visible", int'(bus.visible), 1);
        chk("rst_cell_addr", int'(bus.cell_addr), 0);
        for (int i = 0; i < FR + 100; i++) begin
            bus.en = ($urandom_range(0, 7) != 0);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
